// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment pattern constants and state encoding
// Shared by the seven-segment encoder and the serial decoder.
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'b1000000;
  localparam logic [6:0] SEG7_1     = 7'b1111001;
  localparam logic [6:0] SEG7_2     = 7'b0100100;
  localparam logic [6:0] SEG7_3     = 7'b0110000;
  localparam logic [6:0] SEG7_4     = 7'b0011001;
  localparam logic [6:0] SEG7_5     = 7'b0010010;
  localparam logic [6:0] SEG7_6     = 7'b0000010;
  localparam logic [6:0] SEG7_7     = 7'b1111000;
  localparam logic [6:0] SEG7_8     = 7'b0000000;
  localparam logic [6:0] SEG7_9     = 7'b0011000;
  localparam logic [6:0] SEG7_A     = 7'b0001000;
  localparam logic [6:0] SEG7_B     = 7'b0000011;
  localparam logic [6:0] SEG7_C     = 7'b1000110;
  localparam logic [6:0] SEG7_D     = 7'b0100001;
  localparam logic [6:0] SEG7_E     = 7'b0000110;
  localparam logic [6:0] SEG7_F     = 7'b0001110;
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  typedef enum logic {
    ST_SHIFT = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    logic [6:0] p;
    case (nib)
      4'h0: p = SEG7_0;
      4'h1: p = SEG7_1;
      4'h2: p = SEG7_2;
      4'h3: p = SEG7_3;
      4'h4: p = SEG7_4;
      4'h5: p = SEG7_5;
      4'h6: p = SEG7_6;
      4'h7: p = SEG7_7;
      4'h8: p = SEG7_8;
      4'h9: p = SEG7_9;
      4'hA: p = SEG7_A;
      4'hB: p = SEG7_B;
      4'hC: p = SEG7_C;
      4'hD: p = SEG7_D;
      4'hE: p = SEG7_E;
      default: p = SEG7_F;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg7_pattern_to_nibble.sv
// rtl/seg7_pattern_to_nibble.sv - active-low 7-seg pattern to nibble lookup
// hit_o is low for any pattern outside the hex table; nibble_o is then 0.
module seg7_pattern_to_nibble
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       hit_o
);

  always_comb begin
    nibble_o = 4'h0;
    hit_o    = 1'b1;
    case (pattern_i)
      SEG7_0: nibble_o = 4'h0;
      SEG7_1: nibble_o = 4'h1;
      SEG7_2: nibble_o = 4'h2;
      SEG7_3: nibble_o = 4'h3;
      SEG7_4: nibble_o = 4'h4;
      SEG7_5: nibble_o = 4'h5;
      SEG7_6: nibble_o = 4'h6;
      SEG7_7: nibble_o = 4'h7;
      SEG7_8: nibble_o = 4'h8;
      SEG7_9: nibble_o = 4'h9;
      SEG7_A: nibble_o = 4'hA;
      SEG7_B: nibble_o = 4'hB;
      SEG7_C: nibble_o = 4'hC;
      SEG7_D: nibble_o = 4'hD;
      SEG7_E: nibble_o = 4'hE;
      SEG7_F: nibble_o = 4'hF;
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_serial_decoder.sv
// rtl/seg7_serial_decoder.sv - serial 7-seg pattern stream to word decoder
// Collects NUM_DIGITS patterns (HEX[6] first), decodes them and hands the word out on valid/ready.
module seg7_serial_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int SEG_W      = 7
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    ser_valid,
  output logic                    ser_ready,
  input  logic                    ser_bit,
  input  logic                    ser_sync,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_data,
  output logic                    out_err
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_e           state_q;
  // Only SEG_W-1 bits are stored; the final bit is decoded straight off ser_bit.
  logic [SEG_W-2:0] shreg_q;
  logic [2:0]       bit_cnt_q;
  logic [CW-1:0]    digit_cnt_q;
  logic             err_q;
  logic [DW-1:0]    slots_q;
  logic [DW-1:0]    out_data_q;
  logic             out_err_q;

  logic [2:0]       bit_idx;
  logic [CW-1:0]    digit_idx;
  logic             err_base;
  logic [SEG_W-1:0] pattern;
  logic [3:0]       nibble;
  logic             hit;
  logic [DW-1:0]    slots_d;
  logic             err_d;
  logic             last_bit;
  logic             last_digit;

  seg7_pattern_to_nibble u_lookup (
    .pattern_i (pattern),
    .nibble_o  (nibble),
    .hit_o     (hit)
  );

  // A sync pulse makes the current bit position 0 of digit 0 with a clean error flag.
  always_comb begin
    bit_idx   = ser_sync ? 3'd0 : bit_cnt_q;
    digit_idx = ser_sync ? '0 : digit_cnt_q;
    err_base  = ser_sync ? 1'b0 : err_q;
    pattern   = {shreg_q, ser_bit};
    slots_d   = slots_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (digit_idx == CW'(d)) begin
        slots_d[DW-1-4*d -: 4] = nibble;
      end
    end
    err_d      = err_base | ~hit;
    last_bit   = (bit_idx == 3'd6);
    last_digit = (digit_idx == CW'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SHIFT;
      shreg_q     <= '0;
      bit_cnt_q   <= 3'd0;
      digit_cnt_q <= '0;
      err_q       <= 1'b0;
      slots_q     <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (ser_valid) begin
            shreg_q <= pattern[SEG_W-2:0];
            if (last_bit) begin
              slots_q   <= slots_d;
              bit_cnt_q <= 3'd0;
              if (last_digit) begin
                out_data_q  <= slots_d;
                out_err_q   <= err_d;
                digit_cnt_q <= '0;
                err_q       <= 1'b0;
                state_q     <= ST_HOLD;
              end else begin
                digit_cnt_q <= digit_idx + CW'(1);
                err_q       <= err_d;
              end
            end else begin
              bit_cnt_q   <= bit_idx + 3'd1;
              digit_cnt_q <= digit_idx;
              err_q       <= err_base;
            end
          end else if (ser_sync) begin
            bit_cnt_q   <= 3'd0;
            digit_cnt_q <= '0;
            err_q       <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            bit_cnt_q   <= 3'd0;
            digit_cnt_q <= '0;
            err_q       <= 1'b0;
            state_q     <= ST_SHIFT;
          end
        end
        default: state_q <= ST_SHIFT;
      endcase
    end
  end

  assign ser_ready = (state_q == ST_SHIFT);
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_seg7_serial_decoder.sv
// tb/tb_seg7_serial_decoder.sv - scoreboard bench for seg7_serial_decoder
// Stimulus pushes expected {err,data}; a negedge monitor pops on each accepted frame.
module tb_seg7_serial_decoder;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ser_valid = 1'b0;
  logic       ser_bit = 1'b0;
  logic       ser_sync = 1'b0;
  logic       out_ready = 1'b0;
  logic       ser_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_err;

  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic [6:0] seg_tab[16];
  logic [7:0] byte_v;

  seg7_serial_decoder #(.NUM_DIGITS(2), .SEG_W(7)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_bit   (ser_bit),
    .ser_sync  (ser_sync),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_data", out_data, mon_e[7:0]);
        check("frame_err", out_err, mon_e[8]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    ser_valid = 1'b0;
    ser_sync  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drive_bit(input logic b, input logic s, input bit gaps);
    if (gaps) idle($urandom_range(0, 2));
    ser_valid = 1'b1;
    ser_bit   = b;
    ser_sync  = s;
    tick();
    ser_sync  = 1'b0;
  endtask

  task automatic send_pattern(input logic [6:0] p, input logic sync_first, input bit gaps);
    for (int i = 6; i >= 0; i--) drive_bit(p[i], sync_first && (i == 6), gaps);
  endtask

  task automatic wait_accept(input bit rand_ready);
    ser_valid = 1'b0;
    ser_sync  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!out_valid) return;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("accept_timeout", out_valid, 0);
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // reset
    repeat (3) @(posedge clock);
    #1;
    check("rst_ser_ready_in_reset", ser_ready, 1);
    check("rst_out_valid_in_reset", out_valid, 0);
    reset_n = 1'b1;
    tick();
    check("rst_ser_ready", ser_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_err", out_err, 0);

    // back-to-back frame 0,9 with consumer ready
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h09});
    send_pattern(seg_tab[0], 1'b0, 1'b0);
    for (int i = 6; i >= 1; i--) drive_bit(seg_tab[9][i], 1'b0, 1'b0);
    check("t2_not_early", out_valid, 0);
    drive_bit(seg_tab[9][0], 1'b0, 1'b0);
    ser_valid = 1'b0;
    check("t2_valid_latency", out_valid, 1);
    check("t2_ser_ready_hold", ser_ready, 0);
    tick();
    check("t2_valid_one_cycle", out_valid, 0);
    check("t2_ser_ready_back", ser_ready, 1);

    // backpressure: hold for 5 cycles while extra bits are offered
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h09});
    send_pattern(seg_tab[0], 1'b0, 1'b0);
    send_pattern(seg_tab[9], 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      ser_valid = 1'b1;
      ser_bit   = 1'($urandom_range(0, 1));
      tick();
      check("t3_valid_held", out_valid, 1);
      check("t3_ser_ready_low", ser_ready, 0);
      check("t3_data_held", out_data, 8'h09);
    end
    ser_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t3_ser_ready_after", ser_ready, 1);
    check("t3_valid_after", out_valid, 0);

    // invalid pattern sets err, which must not leak into the next frame
    exp_q.push_back({1'b1, 8'h0F});
    send_pattern(7'b1111111, 1'b0, 1'b0);
    send_pattern(seg_tab[15], 1'b0, 1'b0);
    wait_accept(1'b0);
    exp_q.push_back({1'b0, 8'hBC});
    send_pattern(seg_tab[11], 1'b0, 1'b0);
    send_pattern(seg_tab[12], 1'b0, 1'b0);
    wait_accept(1'b0);

    // garbage then realign with sync on the first bit
    for (int k = 0; k < 9; k++) drive_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    exp_q.push_back({1'b0, 8'h2E});
    send_pattern(seg_tab[2], 1'b1, 1'b0);
    send_pattern(seg_tab[14], 1'b0, 1'b0);
    wait_accept(1'b0);

    // asynchronous reset mid-frame, checked between edges
    for (int i = 6; i >= 2; i--) drive_bit(seg_tab[1][i], 1'b0, 1'b0);
    ser_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_ser_ready", ser_ready, 1);
    check("t6_async_out_valid", out_valid, 0);
    check("t6_async_out_data", out_data, 8'h00);
    check("t6_async_out_err", out_err, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();

    // full byte round trip with random gaps and random consumer stalls
    for (int v = 0; v < 256; v++) begin
      byte_v = 8'(v);
      exp_q.push_back({1'b0, byte_v});
      send_pattern(seg_tab[byte_v[7:4]], 1'b0, 1'b1);
      send_pattern(seg_tab[byte_v[3:0]], 1'b0, 1'b1);
      out_ready = 1'($urandom_range(0, 1));
      wait_accept(1'b1);
    end

    idle(2);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
